// File: rtl/bcd_time_counter_pkg.sv
// Shared types, BCD limits and range check for the digital clock time-of-day core.
package digital_clock_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // Both nibbles must be decimal digits; for valid BCD, numeric order matches decimal order.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
    return (val[3:0] <= 4'd9) && (val[7:4] <= 4'd9) && (val <= max);
  endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control and time bus between the clock front panel logic and the time-of-day core.
// The alarm signals exist only when ALARM_EN is defined.
interface bcd_time_counter_if;

  logic       tick_in;
  logic       en;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hr;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sec_pulse;
`ifdef ALARM_EN
  logic [7:0] alarm_hr_in;
  logic [7:0] alarm_min_in;
  logic       alarm_load;
  logic       alarm_arm;
  logic       alarm_out;
`endif

  modport master (
    output tick_in, en, set_mode, inc_min, inc_hr,
`ifdef ALARM_EN
    output alarm_hr_in, alarm_min_in, alarm_load, alarm_arm,
    input  alarm_out,
`endif
    input  hours, minutes, seconds, sec_pulse
  );

  modport slave (
    input  tick_in, en, set_mode, inc_min, inc_hr,
`ifdef ALARM_EN
    input  alarm_hr_in, alarm_min_in, alarm_load, alarm_arm,
    output alarm_out,
`endif
    output hours, minutes, seconds, sec_pulse
  );

endinterface

// File: rtl/bcd_time_counter_digit_pair.sv
// Two-digit packed BCD counter wrapping MAX -> 00; carry flags the wrap so digit pairs can chain.
module bcd_digit_pair #(
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  // Clear beats increment so a mode change can zero the pair regardless of pending counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value == MAX) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD time-of-day core with tick edge detect, prescaler and RUN/SET modes.
// Optional alarm comparator is built when ALARM_EN is defined.
module bcd_time_counter
  import digital_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter logic [7:0]  RST_HOURS     = 8'h00
) (
  input logic               clk,
  input logic               rst,
  bcd_time_counter_if.slave bus
);

  localparam logic [15:0] PRESCALE_LAST = 16'(TICKS_PER_SEC - 1);

  if (TICKS_PER_SEC < 1 || TICKS_PER_SEC > 65535) begin : g_bad_tps
    $error("TICKS_PER_SEC must be in 1..65535");
  end
  if (!bcd_valid(RST_HOURS, HR_MAX)) begin : g_bad_rst_hours
    $error("RST_HOURS must be a BCD hour 00..23");
  end

  state_t      state, state_nxt;
  logic        tick_q;
  logic        rise;
  logic [15:0] prescale;
  logic        count_rise, sec_tick, enter_set, leave_set;
  logic        min_inc, hr_inc;
  logic        sec_carry, min_carry, hr_carry_unused;
  logic        sec_pulse_q;
  logic [7:0]  hours, minutes, seconds;

  assign rise     = bus.tick_in & ~tick_q;
  assign sec_tick = count_rise && (prescale == PRESCALE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      tick_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_q      <= bus.tick_in;
      sec_pulse_q <= sec_tick;
    end
  end

  // Counting only happens in a settled RUN cycle; the transition edge into SET never counts.
  always_comb begin
    state_nxt  = state;
    enter_set  = 1'b0;
    leave_set  = 1'b0;
    count_rise = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.set_mode) begin
          state_nxt = ST_SET;
          enter_set = 1'b1;
        end else begin
          count_rise = bus.en & rise;
        end
      end
      ST_SET: begin
        if (!bus.set_mode) begin
          state_nxt = ST_RUN;
          leave_set = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || enter_set || leave_set) begin
      prescale <= 16'd0;
    end else if (count_rise) begin
      prescale <= sec_tick ? 16'd0 : prescale + 16'd1;
    end
  end

  // In SET the front-panel pulses drive minutes and hours directly, with no minute-to-hour carry.
  assign min_inc = (state == ST_SET) ? bus.inc_min : sec_carry;
  assign hr_inc  = (state == ST_SET) ? bus.inc_hr  : min_carry;

  bcd_digit_pair #(.MAX(SEC_MAX), .RST_VAL(8'h00)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_tick), .clr(enter_set),
    .value(seconds), .carry(sec_carry)
  );

  bcd_digit_pair #(.MAX(MIN_MAX), .RST_VAL(8'h00)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
    .value(minutes), .carry(min_carry)
  );

  // The day rollover carry out of the hours pair has no consumer.
  bcd_digit_pair #(.MAX(HR_MAX), .RST_VAL(RST_HOURS)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0),
    .value(hours), .carry(hr_carry_unused)
  );

  assign bus.hours     = hours;
  assign bus.minutes   = minutes;
  assign bus.seconds   = seconds;
  assign bus.sec_pulse = sec_pulse_q;

`ifdef ALARM_EN
  logic [7:0] alarm_hr, alarm_min;
  logic       alarm_q;

  // A load with either field out of range is dropped entirely so the pair stays consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_hr  <= 8'h00;
      alarm_min <= 8'h00;
    end else if (bus.alarm_load && bcd_valid(bus.alarm_hr_in, HR_MAX)
                 && bcd_valid(bus.alarm_min_in, MIN_MAX)) begin
      alarm_hr  <= bus.alarm_hr_in;
      alarm_min <= bus.alarm_min_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= bus.alarm_arm && (state == ST_RUN)
                 && (hours == alarm_hr) && (minutes == alarm_min);
    end
  end

  assign bus.alarm_out = alarm_q;
`endif

endmodule
